// File: rtl/mem_bist_engine.sv
// rtl/mem_bist_engine.sv - memory BIST engine: zeros / data=addr / LFSR sweeps with first-failure capture
// Optional MEM_BIST_STOP_ON_FAIL_EN: end the test at the first mismatch.
module mem_bist_engine #(
  parameter int          ADDR_W    = 5,
  parameter int          DATA_W    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          ERR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_CMP, S_DONE} state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [1:0]       pidx;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_nxt;
  logic [1:0]       start_pidx;
  logic [DATA_W-1:0] cur_exp;
  logic             mismatch;
  logic             last_addr;
  logic             more_passes;
  logic             stop_now;
  logic [ERR_W-1:0] err_nxt;

  function automatic logic [DATA_W-1:0] exp_data(input logic [1:0] p,
                                                 input logic [ADDR_W-1:0] a,
                                                 input logic [15:0] l);
    case (p)
      2'd0:    exp_data = '0;
      2'd1:    exp_data = DATA_W'(a);
      default: exp_data = l[DATA_W-1:0];
    endcase
  endfunction

  always_comb begin
    lfsr_nxt    = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    start_pidx  = (mode == 2'd3) ? 2'd0 : mode;
    cur_exp     = exp_data(pidx, mem_addr, lfsr);
    mismatch    = (state == S_CMP) && (mem_rdata != cur_exp);
    last_addr   = &mem_addr;
    more_passes = (mode_q == 2'd3) && (pidx != 2'd2);
    err_nxt     = err_count;
    if (mismatch && !(&err_count))
      err_nxt = err_count + ERR_W'(1);
`ifdef MEM_BIST_STOP_ON_FAIL_EN
    stop_now = mismatch;
`else
    stop_now = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mode_q    <= 2'd0;
      pidx      <= 2'd0;
      lfsr      <= LFSR_SEED;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_q    <= mode;
            pidx      <= start_pidx;
            state     <= S_WRITE;
            mem_addr  <= '0;
            lfsr      <= LFSR_SEED;
            mem_write <= 1'b1;
            mem_wdata <= exp_data(start_pidx, '0, LFSR_SEED);
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
          end
        end
        S_WRITE: begin
          if (last_addr) begin
            state     <= S_READ;
            mem_addr  <= '0;
            lfsr      <= LFSR_SEED;
            mem_write <= 1'b0;
            mem_wdata <= '0;
            mem_read  <= 1'b1;
          end else begin
            mem_addr  <= mem_addr + ADDR_W'(1);
            lfsr      <= lfsr_nxt;
            mem_wdata <= exp_data(pidx, mem_addr + ADDR_W'(1), lfsr_nxt);
          end
        end
        S_READ: begin
          mem_read <= 1'b0;
          state    <= S_CMP;
        end
        S_CMP: begin
          err_count <= err_nxt;
          // Only the first failure of the whole test is kept.
          if (mismatch && err_count == '0) begin
            fail_addr <= mem_addr;
            fail_exp  <= cur_exp;
            fail_act  <= mem_rdata;
          end
          if (stop_now || (last_addr && !more_passes)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else if (last_addr) begin
            pidx      <= pidx + 2'd1;
            state     <= S_WRITE;
            mem_addr  <= '0;
            lfsr      <= LFSR_SEED;
            mem_write <= 1'b1;
            mem_wdata <= exp_data(pidx + 2'd1, '0, LFSR_SEED);
          end else begin
            state    <= S_READ;
            mem_addr <= mem_addr + ADDR_W'(1);
            lfsr     <= lfsr_nxt;
            mem_read <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_engine.sv
// tb/tb_mem_bist_engine.sv - self-checking bench for mem_bist_engine with a stuck-at memory model
module tb_mem_bist_engine;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int N  = 32;
  localparam int EW = 16;
`ifdef MEM_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode  = 2'd0;
  logic          busy, done, pass, mem_write, mem_read;
  logic [EW-1:0] err_count;
  logic [AW-1:0] fail_addr, mem_addr;
  logic [DW-1:0] fail_exp, fail_act, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  mem_bist_engine #(.ADDR_W(AW), .DATA_W(DW), .LFSR_SEED(16'hACE1), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_addr(fail_addr), .fail_exp(fail_exp),
    .fail_act(fail_act), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata));

  // Memory with an optional stuck-at-1 mask on one address, applied on read.
  logic [DW-1:0] mem [N];
  bit            fault_en   = 1'b0;
  logic [AW-1:0] fault_addr = '0;
  logic [DW-1:0] fault_mask = '0;
  logic [AW+DW-1:0] wq[$];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      wq.push_back({mem_addr, mem_wdata});
    end
    if (mem_read)
      mem_rdata <= mem[mem_addr] | ((fault_en && mem_addr == fault_addr) ? fault_mask : '0);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [DW-1:0] ref_exp(input int p, input int a);
    logic [15:0] s;
    logic [31:0] av;
    s  = 16'hACE1;
    av = a;
    if (p == 0) return '0;
    if (p == 1) return av[DW-1:0];
    for (int k = 0; k < a; k++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    return s[DW-1:0];
  endfunction

  task automatic ref_run(input int md, output int err, output int fa, output int fe,
                         output int fact, output int dcyc, output int nw);
    int plist[$];
    bit stopped;
    logic [DW-1:0] e, act;
    if (md == 3) plist = '{0, 1, 2}; else plist = '{md};
    err = 0; fa = 0; fe = 0; fact = 0; stopped = 1'b0;
    dcyc = 3 * N * plist.size() + 1;
    nw   = N * plist.size();
    for (int k = 0; k < plist.size() && !stopped; k++) begin
      for (int a = 0; a < N && !stopped; a++) begin
        e   = ref_exp(plist[k], a);
        act = e | ((fault_en && fault_addr == AW'(a)) ? fault_mask : '0);
        if (act != e) begin
          if (err == 0) begin fa = a; fe = e; fact = act; end
          err++;
          if (STOP) begin
            stopped = 1'b1;
            dcyc = k * 3 * N + N + 2 * a + 3;
            nw   = (k + 1) * N;
          end
        end
      end
    end
  endtask

  task automatic start_run(input logic [1:0] md);
    @(negedge clk);
    mode  = md;
    start = 1'b1;
    wq.delete();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(inout int cyc);
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input int md, input int cyc);
    int err, fa, fe, fact, dcyc, nw, bad;
    logic [AW-1:0] ea;
    ref_run(md, err, fa, fe, fact, dcyc, nw);
    n_cmp++; if (cyc !== dcyc) begin n_fail++; $display("FAIL %s done_cycle got %0d want %0d", tag, cyc, dcyc); end
    n_cmp++; if (err_count !== EW'(err)) begin n_fail++; $display("FAIL %s err_count got %0d want %0d", tag, err_count, err); end
    n_cmp++; if (pass !== (err == 0)) begin n_fail++; $display("FAIL %s pass got %0b want %0b", tag, pass, err == 0); end
    n_cmp++; if (fail_addr !== AW'(fa)) begin n_fail++; $display("FAIL %s fail_addr got %0d want %0d", tag, fail_addr, fa); end
    n_cmp++; if (fail_exp !== DW'(fe)) begin n_fail++; $display("FAIL %s fail_exp got %h want %h", tag, fail_exp, DW'(fe)); end
    n_cmp++; if (fail_act !== DW'(fact)) begin n_fail++; $display("FAIL %s fail_act got %h want %h", tag, fail_act, DW'(fact)); end
    bad = (wq.size() != nw) ? 1 : 0;
    for (int i = 0; i < wq.size() && i < nw; i++) begin
      ea = AW'(i % N);
      if (wq[i] !== {ea, ref_exp((md == 3) ? i / N : md, i % N)}) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL %s write_stream got %0d writes (%0d bad) want %0d", tag, wq.size(), bad, nw); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, done, pass, mem_write, mem_read} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b want 00000", {busy, done, pass, mem_write, mem_read}); end
    n_cmp++; if ({err_count, fail_addr, fail_exp, fail_act} !== '0) begin n_fail++; $display("FAIL reset_status got %h want 0", {err_count, fail_addr, fail_exp, fail_act}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== '0) begin n_fail++; $display("FAIL reset_mem got %h want 0", {mem_addr, mem_wdata}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode1();
    int cyc = 1;
    fault_en = 1'b0;
    start_run(2'd1);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mode1_busy got %b want 1", busy); end
    wait_done(cyc);
    n_cmp++; if (cyc !== 97) begin n_fail++; $display("FAIL mode1_cycle got %0d want 97", cyc); end
    check_result("mode1", 1, cyc);
  endtask

  task automatic test_stuck_mode0();
    int cyc = 1;
    fault_en = 1'b1; fault_addr = 5; fault_mask = 8'h01;
    start_run(2'd0);
    wait_done(cyc);
    n_cmp++; if (fail_act !== 8'h01) begin n_fail++; $display("FAIL stuck0_act got %h want 01", fail_act); end
    check_result("stuck0", 0, cyc);
  endtask

  task automatic test_mode2();
    int cyc = 1;
    logic [7:0] want [3];
    want = '{8'hE1, 8'h70, 8'h38};
    fault_en = 1'b0;
    start_run(2'd2);
    wait_done(cyc);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wq.size() <= i || wq[i] !== {AW'(i), want[i]}) begin
        n_fail++; $display("FAIL lfsr_write%0d got %h want %h", i, (wq.size() > i) ? wq[i] : '0, {AW'(i), want[i]});
      end
    end
    check_result("mode2", 2, cyc);
  endtask

  task automatic test_mode3_stuck();
    int cyc = 1;
    fault_en = 1'b1; fault_addr = 5; fault_mask = 8'h01;
    start_run(2'd3);
    wait_done(cyc);
    check_result("mode3_stuck", 3, cyc);
    fault_en = 1'b0;
  endtask

  task automatic test_reset_abort();
    int cyc = 1;
    int nw;
    start_run(2'd1);
    repeat (9) @(negedge clk);
    n_cmp++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL abort_prewrite got %b want 1", mem_write); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({mem_write, busy} !== 2'b00) begin n_fail++; $display("FAIL abort_async got %b want 00", {mem_write, busy}); end
    nw = wq.size();
    repeat (3) @(negedge clk);
    n_cmp++; if (wq.size() !== nw || mem_read !== 1'b0) begin n_fail++; $display("FAIL abort_quiet got %0d writes want %0d", wq.size(), nw); end
    rst_n = 1'b1;
    start_run(2'd1);
    wait_done(cyc);
    check_result("after_abort", 1, cyc);
  endtask

  task automatic test_start_ignored();
    int cyc = 1;
    start_run(2'd0);
    repeat (19) begin @(negedge clk); cyc++; end
    mode = 2'd1; start = 1'b1;
    @(negedge clk); cyc++;
    start = 1'b0;
    wait_done(cyc);
    check_result("ignored_start", 0, cyc);
    cyc = 1;
    start_run(2'd1);
    n_cmp++; if ({done, busy} !== 2'b01) begin n_fail++; $display("FAIL relaunch_flags got %b want 01", {done, busy}); end
    wait_done(cyc);
    check_result("relaunch", 1, cyc);
  endtask

  task automatic test_random();
    int md, cyc;
    for (int it = 0; it < 8; it++) begin
      md         = $urandom_range(0, 3);
      fault_en   = ($urandom_range(0, 3) != 0);
      fault_addr = AW'($urandom);
      fault_mask = DW'($urandom_range(1, 255));
      cyc = 1;
      start_run(md[1:0]);
      wait_done(cyc);
      check_result($sformatf("rand%0d_m%0d", it, md), md, cyc);
    end
    fault_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode1();
    test_stuck_mode0();
    test_mode2();
    test_mode3_stuck();
    test_reset_abort();
    test_start_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
